// File: rtl/cpu_pkg.sv
// Shared CPU-side encodings and responder defaults for the memory slice.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DEPTH_W_DEF = 8;

  localparam logic [1:0] CPU_IDLE  = 2'b00;
  localparam logic [1:0] CPU_IN    = 2'b01;
  localparam logic [1:0] CPU_CHECK = 2'b10;
  localparam logic [1:0] CPU_RUN   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_CHECK = 2'b10,
    ST_RUN   = 2'b11
  } state_e;

  function automatic state_e decode_state(logic [1:0] cpu_state);
    state_e st;
    unique case (cpu_state)
      CPU_IN:    st = ST_LOAD;
      CPU_CHECK: st = ST_CHECK;
      CPU_RUN:   st = ST_RUN;
      default:   st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Register-file storage: one synchronous write port, two asynchronous read ports.
// Contents are deliberately not reset so a reset preserves loaded program bytes.
module mem_array #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH_W = 8
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [DEPTH_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic [DEPTH_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0]  rdata_a_o,
  input  logic [DEPTH_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0]  rdata_b_o
);

  localparam int unsigned Depth = 2 ** DEPTH_W;

  logic [DATA_W-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: loader intake, readback streaming and CPU read/write service,
// selected by the registered CPU state.
module mem_responder
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DEPTH_W = DEPTH_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         CPUstate,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [DATA_W-1:0]  din,
  output logic [DATA_W-1:0]  dout,
  output logic               dout_valid,
  input  logic               ld_valid,
  input  logic [DATA_W-1:0]  ld_data,
  output logic               ld_ready,
  input  logic               chk_req,
  output logic               chk_valid,
  output logic [DATA_W-1:0]  chk_data,
  output logic [DEPTH_W-1:0] chk_addr,
  output logic               ld_full,
  output logic               conflict,
  output logic               oor
);

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] ptr_q;
  logic               ld_full_q, conflict_q, oor_q;
  logic               chk_valid_q;
  logic [DATA_W-1:0]  chk_data_q;
  logic [DEPTH_W-1:0] chk_addr_q;

  logic               state_stay;
  logic               in_range;
  logic               load_we, run_we;
  logic               mem_we;
  logic [DEPTH_W-1:0] mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  run_rdata, chk_rdata;

  assign state_d    = decode_state(CPUstate);
  assign state_stay = (state_d == state_q);
  assign in_range   = (addr[ADDR_W-1:DEPTH_W] == '0);

  // A loader byte arriving in the cycle the state changes is dropped along with the pointer.
  assign load_we = (state_q == ST_LOAD) && ld_valid && !ld_full_q && state_stay;
  assign run_we  = (state_q == ST_RUN) && mem_write && !mem_read && in_range;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = ld_data;
    if (load_we) begin
      mem_we = 1'b1;
    end else if (run_we) begin
      mem_we    = 1'b1;
      mem_waddr = addr[DEPTH_W-1:0];
      mem_wdata = din;
    end
  end

  mem_array #(
    .DATA_W  (DATA_W),
    .DEPTH_W (DEPTH_W)
  ) u_mem_array (
    .clk_i     (clk),
    .we_i      (mem_we),
    .waddr_i   (mem_waddr),
    .wdata_i   (mem_wdata),
    .raddr_a_i (addr[DEPTH_W-1:0]),
    .rdata_a_o (run_rdata),
    .raddr_b_i (ptr_q),
    .rdata_b_o (chk_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      ld_full_q   <= 1'b0;
      conflict_q  <= 1'b0;
      oor_q       <= 1'b0;
      chk_valid_q <= 1'b0;
      chk_data_q  <= '0;
      chk_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      chk_valid_q <= 1'b0;
      if (!state_stay) begin
        ptr_q <= '0;
        if (state_d == ST_LOAD) begin
          ld_full_q <= 1'b0;
        end
      end else begin
        unique case (state_q)
          ST_LOAD: begin
            if (load_we) begin
              ptr_q <= ptr_q + 1'b1;
              if (ptr_q == '1) begin
                ld_full_q <= 1'b1;
              end
            end
          end
          ST_CHECK: begin
            if (chk_req) begin
              chk_valid_q <= 1'b1;
              chk_data_q  <= chk_rdata;
              chk_addr_q  <= ptr_q;
              ptr_q       <= ptr_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (state_q == ST_RUN) begin
        if (mem_read && mem_write) begin
          conflict_q <= 1'b1;
        end
        if ((mem_read || mem_write) && !in_range) begin
          oor_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    dout       = '0;
    dout_valid = 1'b0;
    if (state_q == ST_RUN) begin
      dout_valid = mem_read;
      if (in_range) begin
        dout = run_rdata;
      end
    end
  end

  assign ld_ready  = (state_q == ST_LOAD) && !ld_full_q;
  assign chk_valid = chk_valid_q;
  assign chk_data  = chk_data_q;
  assign chk_addr  = chk_addr_q;
  assign ld_full   = ld_full_q;
  assign conflict  = conflict_q;
  assign oor       = oor_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: load, readback, RUN access, sticky flags and reset.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  CPUstate;
  logic [15:0] addr;
  logic        mem_read, mem_write;
  logic [7:0]  din, dout;
  logic        dout_valid;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        chk_req, chk_valid;
  logic [7:0]  chk_data, chk_addr;
  logic        ld_full, conflict, oor;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .CPUstate   (CPUstate),
    .addr       (addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .chk_req    (chk_req),
    .chk_valid  (chk_valid),
    .chk_data   (chk_data),
    .chk_addr   (chk_addr),
    .ld_full    (ld_full),
    .conflict   (conflict),
    .oor        (oor)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_rb [4];
    rst = 1'b0; CPUstate = 2'b00; addr = '0; mem_read = 0; mem_write = 0; din = '0;
    ld_valid = 0; ld_data = '0; chk_req = 0;
    step(); step();
    chk("rst_ld_full", ld_full, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_oor", oor, 0);
    chk("rst_chk_valid", chk_valid, 0);
    chk("rst_chk_data", chk_data, 8'h00);
    chk("rst_chk_addr", chk_addr, 8'h00);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);

    // 1. Load three bytes, then stream them back
    rst = 1'b1; CPUstate = 2'b01;
    step();
    chk("load_ready", ld_ready, 1);
    ld_valid = 1; ld_data = 8'h01; step();
    ld_data = 8'h20; step();
    ld_data = 8'h00; step();
    ld_valid = 0;
    chk("load_ptr3", dut.ptr_q, 8'd3);
    chk("load_not_full", ld_full, 0);
    CPUstate = 2'b10;
    step();
    chk("chk_idle_valid", chk_valid, 0);
    chk_req = 1; step();
    chk("chk0_valid", chk_valid, 1);
    chk("chk0_data", chk_data, 8'h01);
    chk("chk0_addr", chk_addr, 8'h00);
    step();
    chk("chk1_data", chk_data, 8'h20);
    chk("chk1_addr", chk_addr, 8'h01);
    step();
    chk("chk2_data", chk_data, 8'h00);
    chk("chk2_addr", chk_addr, 8'h02);
    chk_req = 0; step();
    chk("chk_end_valid", chk_valid, 0);

    // 2. Zero-latency RUN read
    CPUstate = 2'b11;
    step();
    addr = 16'h0001; mem_read = 1; #1;
    chk("run_rd1_dout", dout, 8'h20);
    chk("run_rd1_valid", dout_valid, 1);

    // 3. Write then read back next cycle
    mem_read = 0; mem_write = 1; addr = 16'h0040; din = 8'hAB;
    step();
    mem_write = 0; mem_read = 1; #1;
    chk("run_wr_rd_dout", dout, 8'hAB);
    chk("run_wr_conflict", conflict, 0);
    chk("run_wr_oor", oor, 0);

    // 4. Simultaneous read/write: read wins, write dropped
    addr = 16'h0001; mem_write = 1; din = 8'h77; #1;
    chk("conf_dout", dout, 8'h20);
    step();
    chk("conf_flag", conflict, 1);
    mem_write = 0; #1;
    chk("conf_mem_kept", dout, 8'h20);

    // 5. Out-of-range access
    addr = 16'h0140; #1;
    chk("oor_dout", dout, 8'h00);
    chk("oor_valid", dout_valid, 1);
    step();
    chk("oor_flag", oor, 1);
    mem_read = 0; mem_write = 1; din = 8'h55;
    step();
    mem_write = 0; mem_read = 1; addr = 16'h0040; #1;
    chk("oor_wr_ignored", dout, 8'hAB);
    chk("conf_sticky", conflict, 1);

    // Strobes ignored outside RUN
    CPUstate = 2'b00;
    step();
    chk("idle_dout", dout, 8'h00);
    chk("idle_dout_valid", dout_valid, 0);
    mem_read = 0;

    // 6. Fill all 256 locations, then overflow
    CPUstate = 2'b01;
    step();
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1; ld_data = 8'(i) ^ 8'h5A;
      step();
    end
    chk("full_flag", ld_full, 1);
    chk("full_ready", ld_ready, 0);
    chk("full_ptr_wrap", dut.ptr_q, 8'd0);
    ld_data = 8'hEE; step();
    ld_valid = 0;
    chk("full_refused_ptr", dut.ptr_q, 8'd0);
    chk("full_sticky", ld_full, 1);
    CPUstate = 2'b10;
    step();
    chk_req = 1; step(); chk_req = 0;
    chk("refused_byte", chk_data, 8'h5A);
    CPUstate = 2'b01;
    step();
    chk("reentry_full_clr", ld_full, 0);
    chk("reentry_ready", ld_ready, 1);
    ld_valid = 1; ld_data = 8'hC0; step();
    ld_data = 8'hC1; step();
    ld_valid = 0;
    rst = 1'b0; step(); rst = 1'b1;
    chk("midrst_ptr", dut.ptr_q, 8'd0);
    chk("midrst_full", ld_full, 0);
    chk("midrst_conflict", conflict, 0);
    chk("midrst_oor", oor, 0);
    chk("midrst_ready", ld_ready, 0);
    CPUstate = 2'b10;
    step();
    exp_rb[0] = 8'hC0; exp_rb[1] = 8'hC1; exp_rb[2] = 8'h58; exp_rb[3] = 8'h59;
    chk_req = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rb%0d_data", i), chk_data, exp_rb[i]);
      chk($sformatf("rb%0d_addr", i), chk_addr, 32'(i));
    end
    chk_req = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
